// File: rtl/alu_pkg.sv
// Purpose : shared definitions for the ALU sequencer and the external ALU it drives.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: ALU opcode constants OP_ADD..OP_SHR and the sequencer state enum.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Purpose : accumulator sequencer; accepts LOAD/EXEC commands, drives an external
//           combinational ALU from registers and returns the accumulator plus flags.
// Latency : accept edge -> rsp_valid: 1 cycle for LOAD, 2 cycles for EXEC.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
// Ports   : clk/rst (sync, active-high); cmd_* command channel (valid/ready);
//           alu_a/alu_b/alu_opcode -> ALU, alu_result/alu_carry_out/alu_zero <- ALU;
//           rsp_* response channel (valid/ready); op_count = completed responses mod 256.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_load,
   input  logic [2:0]        cmd_opcode,
   input  logic [DATA_W-1:0] cmd_operand,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry_out,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              rsp_zero,
   output logic [7:0]        op_count
);

   seq_state_t        state_q, state_d;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] operand_q;
   logic [2:0]        opcode_q;
   logic              carry_q;
   logic              zero_q;
   logic [7:0]        count_q;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next-state logic; commands arriving outside IDLE are simply not looked at
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_valid) state_d = cmd_load ? ST_RESP : ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // handshake outputs
   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
   end

   // datapath registers; ALU inputs only move on accept (operand/opcode, or acc for
   // LOAD) and on EXEC completion (acc), so the ALU sees a stable vector in EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         operand_q <= '0;
         opcode_q  <= 3'b000;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_load) begin
                     acc_q   <= cmd_operand;
                     carry_q <= 1'b0;
                     zero_q  <= (cmd_operand == '0);
                  end else begin
                     operand_q <= cmd_operand;
                     opcode_q  <= cmd_opcode;
                  end
               end
            end
            ST_EXEC: begin
               acc_q   <= alu_result;
               carry_q <= alu_carry_out;
               zero_q  <= alu_zero;
            end
            ST_RESP: begin
               if (rsp_ready) count_q <= count_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign alu_a      = acc_q;
   assign alu_b      = operand_q;
   assign alu_opcode = opcode_q;
   assign rsp_data   = acc_q;
   assign rsp_carry  = carry_q;
   assign rsp_zero   = zero_q;
   assign op_count   = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose : self-checking bench for alu_sequencer with a behavioural ALU attached.
// Latency : checks 1/2-cycle response latency and hold-under-backpressure.
// Backpressure: rsp_ready driven low for programmable cycles per command.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready, cmd_load;
   logic [2:0]        cmd_opcode;
   logic [DATA_W-1:0] cmd_operand;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [2:0]        alu_opcode;
   logic              alu_carry_out, alu_zero;
   logic              rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_carry, rsp_zero;
   logic [7:0]        op_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       carry;
      logic       zero;
      logic [7:0] data;
   } rsp_t;

   rsp_t exp_q[$];

   // reference model state
   logic [7:0] m_acc, m_b, m_count;
   logic [2:0] m_op;

   always #5 clk = ~clk;

   alu_sequencer #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
      .op_count(op_count)
   );

   // behavioural ALU: shifts are by one bit, b ignored for not/shl/shr
   function automatic rsp_t alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      rsp_t r;
      logic [8:0] s;
      r = '0;
      case (op)
         OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r.data = s[7:0]; r.carry = s[8]; end
         OP_SUB: begin r.data = a - b; r.carry = (a < b); end
         OP_AND: r.data = a & b;
         OP_OR:  r.data = a | b;
         OP_XOR: r.data = a ^ b;
         OP_NOT: r.data = ~a;
         OP_SHL: r.data = a << 1;
         default: r.data = a >> 1;
      endcase
      r.zero = (r.data == 8'd0);
      return r;
   endfunction

   always_comb begin
      rsp_t r;
      r = alu_fn(alu_a, alu_b, alu_opcode);
      alu_result    = r.data;
      alu_carry_out = r.carry;
      alu_zero      = r.zero;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         chk("rst_rsp_valid", rsp_valid, 0);
      end
      rst = 1'b0;
      m_acc = 0; m_b = 0; m_op = 0; m_count = 0;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic check_idle_regs();
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_alu_a",     alu_a, m_acc);
      chk("idle_alu_b",     alu_b, m_b);
      chk("idle_alu_op",    alu_opcode, m_op);
      chk("idle_op_count",  op_count, m_count);
   endtask

   // one full command: issue, latency check, optional backpressure, handshake
   task automatic do_cmd(input logic ld, input logic [2:0] opc, input logic [7:0] opd,
                         input int hold);
      int   n;
      int   lat;
      rsp_t e, got, held;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_load = ld; cmd_opcode = opc; cmd_operand = opd;
      if (ld) begin
         e.data = opd; e.carry = 1'b0; e.zero = (opd == 8'd0);
      end else begin
         m_b = opd; m_op = opc;
         e = alu_fn(m_acc, opd, opc);
      end
      m_acc = e.data;
      exp_q.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 10);
      chk(ld ? "lat_load" : "lat_exec", lat, ld ? 1 : 2);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         got = {rsp_carry, rsp_zero, rsp_data};
         chk("rsp", got, e);
      end
      chk("rsp_alu_b", alu_b, m_b);
      chk("rsp_alu_op", alu_opcode, m_op);
      held = {rsp_carry, rsp_zero, rsp_data};
      for (int k = 0; k < hold; k++) begin
         cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 8'hAA; cmd_opcode = OP_XOR;
         @(negedge clk);
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_fields", {rsp_carry, rsp_zero, rsp_data}, held);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      m_count = m_count + 8'd1;
      @(negedge clk);
      check_idle_regs();
      chk("idle_acc", rsp_data, m_acc);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_opcode = 3'b000;
      cmd_operand = 8'h00; rsp_ready = 1'b0;
      m_acc = 0; m_b = 0; m_op = 0; m_count = 0;

      // reset state
      do_reset(2);
      check_idle_regs();
      chk("rst_rsp_data",  rsp_data, 0);
      chk("rst_rsp_carry", rsp_carry, 0);
      chk("rst_rsp_zero",  rsp_zero, 0);

      // LOAD then EXEC add
      do_cmd(1'b1, OP_ADD, 8'h05, 0);
      do_cmd(1'b0, OP_ADD, 8'h03, 0);
      chk("add_result", rsp_data, 8'h08);
      chk("count_after_two", op_count, 8'd2);

      // add overflow gives carry and zero
      do_cmd(1'b1, OP_ADD, 8'hFF, 0);
      do_cmd(1'b0, OP_ADD, 8'h01, 0);
      chk("ovf_data", {rsp_carry, rsp_zero, rsp_data}, {1'b1, 1'b1, 8'h00});

      // sub with borrow, then shift right
      do_cmd(1'b1, OP_ADD, 8'h03, 0);
      do_cmd(1'b0, OP_SUB, 8'h05, 0);
      chk("sub_data", {rsp_carry, rsp_zero, rsp_data}, {1'b1, 1'b0, 8'hFE});
      do_cmd(1'b0, OP_SHR, 8'h00, 0);
      chk("shr_data", {rsp_carry, rsp_data}, {1'b0, 8'h7F});

      // backpressure: 3 cycles rsp_ready low with commands offered
      do_cmd(1'b0, OP_XOR, 8'h0F, 3);
      do_cmd(1'b1, OP_ADD, 8'h00, 2);

      // reset during EXEC discards the command
      do_reset(1);
      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opcode = OP_ADD; cmd_operand = 8'h11;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_cmd_ready", cmd_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rexec_cmd_ready", cmd_ready, 1);
      chk("rexec_acc",       rsp_data, 0);
      chk("rexec_alu_b",     alu_b, 0);
      begin
         int seen = 0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
         end
         chk("rexec_no_rsp", seen, 0);
      end
      chk("rexec_count", op_count, 0);

      // randomised run across the op_count wrap
      for (int i = 0; i < 258; i++) begin
         do_cmd(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 255)), $urandom_range(0, 2));
      end
      chk("wrap_count", op_count, 8'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got stuck, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, default 8, datapath width of accumulator, operands and ALU ports.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: cmd_valid  input  1  command offered.
REQ-005 Port: cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 Port: cmd_load  input  1  1 = LOAD operand into accumulator; 0 = EXEC ALU operation.
REQ-007 Port: cmd_opcode  input  3  ALU opcode for EXEC (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 shl, 111 shr); ignored for LOAD.
REQ-008 Port: cmd_operand  input  DATA_W  LOAD value or ALU operand b.
REQ-009 Port: alu_a  output  DATA_W  ALU operand a, driven from accumulator.
REQ-010 Port: alu_b  output  DATA_W  ALU operand b, driven from operand register.
REQ-011 Port: alu_opcode  output  3  ALU opcode, driven from opcode register.
REQ-012 Port: alu_result  input  DATA_W  ALU result, combinational from alu_a/alu_b/alu_opcode.
REQ-013 Port: alu_carry_out  input  1  ALU carry/borrow.
REQ-014 Port: alu_zero  input  1  ALU zero flag.
REQ-015 Port: rsp_valid  output  1  response available.
REQ-016 Port: rsp_ready  input  1  consumer takes response.
REQ-017 Port: rsp_data  output  DATA_W  accumulator value after the command.
REQ-018 Port: rsp_carry  output  1  carry flag after the command.
REQ-019 Port: rsp_zero  output  1  zero flag after the command.
REQ-020 Port: op_count  output  8  number of completed responses, wraps 255 -> 0.

Function
REQ-021 States SHALL be IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-022 IDLE: cmd_valid=1 with cmd_load=1 -> acc<=cmd_operand, carry<=0, zero<=(cmd_operand==0), go RESP.
REQ-023 IDLE: cmd_valid=1 with cmd_load=0 -> operand reg<=cmd_operand, opcode reg<=cmd_opcode, go EXEC.
REQ-024 EXEC lasts exactly one cycle: acc<=alu_result, carry<=alu_carry_out, zero<=alu_zero, go RESP.
REQ-025 Latency from accept edge to rsp_valid high: 1 cycle for LOAD, 2 cycles for EXEC.
REQ-026 RESP: rsp_data/rsp_carry/rsp_zero SHALL be driven from registers and held stable while rsp_ready=0.
REQ-027 RESP with rsp_ready=1 -> op_count increments (modulo 256), go IDLE; next command not accepted before the following cycle.
REQ-028 alu_a/alu_b/alu_opcode SHALL be registered values, stable in all states; ALU inputs change only on command accept or EXEC completion.
REQ-029 Arithmetic fully delegated to ALU; carry for sub equals ALU borrow bit (1 when a<b); carry for non add/sub opcodes = 0 as returned by ALU.
REQ-030 cmd_valid in EXEC or RESP SHALL be ignored (no state change); accumulator persists across commands.

Reset
REQ-031 rst=1 at a rising edge SHALL force state IDLE, acc=0, operand reg=0, opcode reg=000, carry=0, zero=0, op_count=0, in any state including EXEC/RESP.
REQ-032 During and after reset: cmd_ready=1 (after release), rsp_valid=0, rsp_data=0, alu_a=0, alu_b=0, alu_opcode=000; an in-flight response is discarded.

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode constants OP_ADD..OP_SHR and the sequencer state enum.
REQ-034 No sub-module; the existing alu instance SHALL be connected externally at the top level (alu_a->a, alu_b->b, alu_opcode->opcode).

Verification
REQ-035 Reset held 2 cycles -> all outputs 0, cmd_ready=1 after release, op_count=0.
REQ-036 LOAD 0x05, then EXEC add 0x03 -> responses 0x05/c0/z0 then 0x08/c0/z0, second rsp_valid 2 cycles after accept, op_count=2.
REQ-037 LOAD 0xFF, EXEC add 0x01 -> rsp_data=0x00, rsp_carry=1, rsp_zero=1.
REQ-038 LOAD 0x03, EXEC sub 0x05 -> rsp_data=0xFE, rsp_carry=1, rsp_zero=0; then EXEC shr 0x00 -> 0x7F, carry 0.
REQ-039 rsp_ready low 3 cycles during RESP with cmd_valid=1 -> rsp fields stable, cmd_ready=0, no command accepted until after handshake.
REQ-040 rst asserted in EXEC cycle -> next cycle IDLE, acc=0, rsp_valid never asserted for that command, op_count unchanged from 0.
